mem_dbus_ctrl: RTL and testbench

MEM-stage data-bus controller. It sits directly upstream of the MEM/WB pipeline register. It converts the EX/MEM load/store request into an SRAM-like data-bus transaction (req / addr_ok / data_ok) and generates `byte_valid` and the raw `mem_rdata` word consumed by MEM/WB. It raises `stall0` while an access is outstanding. It also drains bus transactions that were accepted before an interrupt flushed the instruction.

---
 rtl/mem_dbus_ctrl_pkg.sv | 17 +
 rtl/mem_dbus_ctrl_lane_gen.sv | 38 +++
 rtl/mem_dbus_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared types for the MEM-stage data-bus controller.
// Access-size codes and FSM state encoding.
package mem_dbus_ctrl_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        DBUS_IDLE  = 3'd0,
        DBUS_ADDR  = 3'd1,
        DBUS_DATA  = 3'd2,
        DBUS_HOLD  = 3'd3,
        DBUS_DRAIN = 3'd4
    } dbus_state_e;

endpackage

// File: rtl/mem_dbus_ctrl_lane_gen.sv
// Byte-lane enables, store-data replication and alignment check.
// MEM_ADDR_CHECK_EN enables misaligned-address detection.
module dbus_lane_gen
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [1:0]  mem_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    output logic [3:0]  lanes,
    output logic [31:0] wdata_rep,
    output logic        addr_err
);

    always_comb begin
        lanes     = 4'h0;
        wdata_rep = wdata_in;
        case (mem_size)
            MEM_SIZE_B: begin
                lanes     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata_in[7:0]}};
            end
            MEM_SIZE_H: begin
                lanes     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata_in[15:0]}};
            end
            MEM_SIZE_W: lanes = 4'hF;
            default: ;
        endcase
    end

`ifdef MEM_ADDR_CHECK_EN
    assign addr_err = ((mem_size == MEM_SIZE_H) & addr_lo[0])
                    | ((mem_size == MEM_SIZE_W) & (|addr_lo));
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller (req/addr_ok/data_ok) with irq drain.
// MEM_ADDR_CHECK_EN enables adel/ades instead of address forcing.
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] ALU_result,
    input  logic [31:0]       rf_rdata1_fw,
    input  logic              irq,
    input  logic              stall_ext,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [3:0]        byte_valid,
    output logic [31:0]       mem_rdata,
    output logic              stall0,
    output logic              adel,
    output logic              ades
);

    dbus_state_e state_q, state_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  lanes;
    logic        addr_err;
    logic        ls;
    logic        op;

    dbus_lane_gen u_lane_gen (
        .mem_size  (mem_size),
        .addr_lo   (ALU_result[1:0]),
        .wdata_in  (rf_rdata1_fw),
        .lanes     (lanes),
        .wdata_rep (data_wdata),
        .addr_err  (addr_err)
    );

    assign ls         = mem_valid & (mem_read | mem_write);
    assign op         = ls & ~addr_err & ~irq;
    assign byte_valid = ls ? lanes : 4'h0;
    assign data_size  = mem_size;
    assign data_wr    = data_req & mem_write;

`ifdef MEM_ADDR_CHECK_EN
    assign adel      = mem_valid & mem_read & addr_err & ~irq;
    assign ades      = mem_valid & mem_write & addr_err & ~irq;
    assign data_addr = ALU_result;
`else
    assign adel = 1'b0;
    assign ades = 1'b0;
    always_comb begin
        data_addr = ALU_result;
        if (mem_size == MEM_SIZE_W)
            data_addr[1:0] = 2'b00;
        else if (mem_size == MEM_SIZE_H)
            data_addr[0] = 1'b0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        data_req  = 1'b0;
        stall0    = 1'b0;
        mem_rdata = rdata_q;
        unique case (state_q)
            DBUS_IDLE: begin
                data_req = op;
                stall0   = op;
                if (op)
                    state_d = data_addr_ok ? DBUS_DATA : DBUS_ADDR;
            end
            DBUS_ADDR: begin
                data_req = 1'b1;
                stall0   = 1'b1;
                if (data_addr_ok)
                    state_d = irq ? DBUS_DRAIN : DBUS_DATA;
            end
            DBUS_DATA: begin
                stall0 = ~data_data_ok;
                if (data_data_ok) begin
                    state_d = DBUS_IDLE;
                    // A flushed instruction must not see its read data.
                    if (!irq) begin
                        mem_rdata = data_rdata;
                        rdata_d   = data_rdata;
                        if (stall_ext) begin
                            rbuf_d  = data_rdata;
                            state_d = DBUS_HOLD;
                        end
                    end
                end else if (irq) begin
                    state_d = DBUS_DRAIN;
                end
            end
            DBUS_HOLD: begin
                mem_rdata = rbuf_q;
                if (!stall_ext || irq)
                    state_d = DBUS_IDLE;
            end
            DBUS_DRAIN: begin
                stall0 = 1'b1;
                if (data_data_ok)
                    state_d = DBUS_IDLE;
            end
            default: state_d = DBUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DBUS_IDLE;
            rbuf_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl; expected values computed by hand.
// Honours MEM_ADDR_CHECK_EN for the misaligned half-load case.
module tb_mem_dbus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] ALU_result;
    logic [31:0] rf_rdata1_fw;
    logic        irq;
    logic        stall_ext;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  byte_valid;
    logic [31:0] mem_rdata;
    logic        stall0;
    logic        adel;
    logic        ades;

    int n_checks = 0;
    int n_errors = 0;

    mem_dbus_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .ALU_result   (ALU_result),
        .rf_rdata1_fw (rf_rdata1_fw),
        .irq          (irq),
        .stall_ext    (stall_ext),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .byte_valid   (byte_valid),
        .mem_rdata    (mem_rdata),
        .stall0       (stall0),
        .adel         (adel),
        .ades         (ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'd0;
        ALU_result   = 32'h0;
        rf_rdata1_fw = 32'h0;
        irq          = 1'b0;
        stall_ext    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clk);
        check({tag, "_req"},   {31'h0, data_req}, 32'h0);
        check({tag, "_wr"},    {31'h0, data_wr},  32'h0);
        check({tag, "_stall"}, {31'h0, stall0},   32'h0);
        check({tag, "_rdata"}, mem_rdata,         32'h0);
        check({tag, "_adel"},  {31'h0, adel},     32'h0);
        check({tag, "_ades"},  {31'h0, ades},     32'h0);
    endtask

    task automatic load(input logic [1:0] sz, input logic [31:0] a);
        mem_valid  = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        mem_size   = sz;
        ALU_result = a;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        check_reset_outs("rst");

        // word load, best-case latency
        cyc();
        load(2'd2, 32'h100);
        data_addr_ok = 1'b1;
        @(negedge clk);
        check("wl_req0",   {31'h0, data_req}, 32'h1);
        check("wl_stall0", {31'h0, stall0},   32'h1);
        check("wl_bv",     {28'h0, byte_valid}, 32'hF);
        check("wl_addr",   data_addr, 32'h100);
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        check("wl_stall1", {31'h0, stall0},   32'h0);
        check("wl_rdata",  mem_rdata, 32'hDEADBEEF);
        check("wl_req1",   {31'h0, data_req}, 32'h0);
        cyc();
        idle_inputs();
        @(negedge clk);
        check("wl_hold", mem_rdata, 32'hDEADBEEF);
        check("wl_idle", {31'h0, stall0}, 32'h0);

        // irq in IDLE: nothing issued
        cyc();
        load(2'd2, 32'h300);
        irq = 1'b1;
        @(negedge clk);
        check("irqi_req",   {31'h0, data_req}, 32'h0);
        check("irqi_stall", {31'h0, stall0},   32'h0);

        // byte store with addr_ok after 3 wait cycles
        cyc();
        idle_inputs();
        mem_valid    = 1'b1;
        mem_write    = 1'b1;
        mem_size     = 2'd0;
        ALU_result   = 32'h103;
        rf_rdata1_fw = 32'h0000005A;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            @(negedge clk);
            check($sformatf("bs_req%0d", i), {31'h0, data_req}, 32'h1);
            check($sformatf("bs_stall%0d", i), {31'h0, stall0}, 32'h1);
            cyc();
        end
        check("bs_wdata", data_wdata, 32'h5A5A5A5A);
        check("bs_bv",    {28'h0, byte_valid}, 32'h8);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        @(negedge clk);
        check("bs_req4",   {31'h0, data_req}, 32'h0);
        check("bs_stall4", {31'h0, stall0},   32'h0);
        cyc();
        idle_inputs();

        // load completing under external stall -> HOLD
        load(2'd2, 32'h40);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h12345678;
        stall_ext    = 1'b1;
        @(negedge clk);
        check("hl_rdata0", mem_rdata, 32'h12345678);
        check("hl_stall0", {31'h0, stall0}, 32'h0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            data_data_ok = 1'b0;
            data_rdata   = 32'hFFFFFFFF;
            stall_ext    = (i < 3);
            @(negedge clk);
            check($sformatf("hl_rdata%0d", i), mem_rdata, 32'h12345678);
            check($sformatf("hl_req%0d", i), {31'h0, data_req}, 32'h0);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        check("hl_after", mem_rdata, 32'h12345678);

        // irq in DATA before data_ok -> DRAIN
        load(2'd2, 32'h200);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        irq          = 1'b1;
        @(negedge clk);
        check("dr_stall0", {31'h0, stall0}, 32'h1);
        cyc();
        idle_inputs();
        @(negedge clk);
        check("dr_stall1", {31'h0, stall0},   32'h1);
        check("dr_req1",   {31'h0, data_req}, 32'h0);
        cyc();
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFEF00D;
        @(negedge clk);
        check("dr_stall2", {31'h0, stall0}, 32'h1);
        check("dr_rdata2", mem_rdata, 32'h12345678);
        cyc();
        idle_inputs();
        load(2'd2, 32'h204);
        @(negedge clk);
        check("dr_idle_req", {31'h0, data_req}, 32'h1);
        check("dr_rdata3",   mem_rdata, 32'h12345678);

        // now in ADDR; reset mid-transaction
        cyc();
        @(negedge clk);
        check("ad_req",   {31'h0, data_req}, 32'h1);
        check("ad_stall", {31'h0, stall0},   32'h1);
        cyc();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_reset_outs("mrst");
        cyc();
        load(2'd2, 32'h10);
        data_addr_ok = 1'b1;
        @(negedge clk);
        check("mrst_idle_req", {31'h0, data_req}, 32'h1);
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BADF00D;
        cyc();
        idle_inputs();

        // misaligned half load
        load(2'd1, 32'h101);
        data_addr_ok = 1'b1;
        @(negedge clk);
`ifdef MEM_ADDR_CHECK_EN
        check("hm_adel",  {31'h0, adel},     32'h1);
        check("hm_req",   {31'h0, data_req}, 32'h0);
        check("hm_stall", {31'h0, stall0},   32'h0);
`else
        check("hm_addr", data_addr, 32'h100);
        check("hm_req",  {31'h0, data_req}, 32'h1);
        check("hm_bv",   {28'h0, byte_valid}, 32'h3);
        check("hm_adel", {31'h0, adel}, 32'h0);
        cyc();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000BEEF;
        @(negedge clk);
        check("hm_rdata", mem_rdata, 32'h0000BEEF);
`endif
        cyc();
        idle_inputs();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
